// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Optional fairness feature is selected by the MEM_ARB_FAIR_EN macro in mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int ADDR_W           = 16;
    localparam int DATA_W           = 16;
    localparam int BANK_LSB         = 1;
    localparam int BANK_W           = 2;
    localparam int NUM_BANKS        = 1 << BANK_W;
    localparam int MEM_LAT_DEF      = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_LSB +: BANK_W];
    endfunction

endpackage

// File: rtl/mem_arb_retpipe.sv
// Latency-matched owner tag pipeline; steers returning memory read data
// to the I or D return port when the issuing read's tag reaches the last stage.
module mem_arb_retpipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  owner_t            load_tag,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata
);

    owner_t [MEM_LAT-1:0] tags;
    owner_t               head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < MEM_LAT; s++) tags[s] <= OWN_NONE;
        end else begin
            tags[0] <= load_tag;
            for (int s = 1; s < MEM_LAT; s++) tags[s] <= tags[s-1];
        end
    end

    assign head = tags[MEM_LAT-1];

    // Gated by rst so stale tags never show a valid while reset is held.
    always_comb begin
        i_valid = rst && (head == OWN_I);
        d_valid = rst && (head == OWN_D);
        i_rdata = i_valid ? mem_rdata : '0;
        d_rdata = d_valid ? mem_rdata : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing banked main memory between I-cache and D-cache.
// Define MEM_ARB_FAIR_EN to let a starved I request win over D after STARVE_LIMIT D grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = MEM_LAT_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_gnt,
    output logic                 i_valid,
    output logic [DATA_W-1:0]    i_rdata,
    input  logic                 d_req,
    input  logic                 d_wr,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_gnt,
    output logic                 d_valid,
    output logic [DATA_W-1:0]    d_rdata,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_stall,
    input  logic [NUM_BANKS-1:0] mem_busy
);

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("mem_arbiter: MEM_LAT must be 1..4 and STARVE_LIMIT >= 1");
    end

    logic [BANK_W-1:0] i_bank, d_bank;
    logic              i_elig, d_elig;
    logic              i_first;
    logic              grant_i, grant_d;
    owner_t            load_tag;

    assign i_bank = bank_of(i_addr);
    assign d_bank = bank_of(d_addr);

    // A busy bank only disqualifies its own requester, never the other one.
    assign i_elig = rst && i_req && !mem_stall && !mem_busy[i_bank];
    assign d_elig = rst && d_req && !mem_stall && !mem_busy[d_bank];

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_i || !i_req) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign i_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));
`else
    assign i_first = 1'b0;
`endif

    assign grant_d = d_elig && !(i_elig && i_first);
    assign grant_i = i_elig && !grant_d;
    assign i_gnt   = grant_i;
    assign d_gnt   = grant_d;

    // Write data is only driven for writes; reads leave the bus at zero.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        load_tag  = OWN_NONE;
        if (grant_d) begin
            mem_addr = d_addr;
            if (d_wr) begin
                mem_wr    = 1'b1;
                mem_wdata = d_wdata;
            end else begin
                mem_rd   = 1'b1;
                load_tag = OWN_D;
            end
        end else if (grant_i) begin
            mem_rd   = 1'b1;
            mem_addr = i_addr;
            load_tag = OWN_I;
        end
    end

    mem_arb_retpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_retpipe (
        .clk       (clk),
        .rst       (rst),
        .load_tag  (load_tag),
        .mem_rdata (mem_rdata),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mem_arbiter;

    localparam int LAT    = 2;
    localparam int STARVE = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, mem_stall;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  mem_busy;
    logic        i_gnt, i_valid, d_gnt, d_valid, mem_rd, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_busy(mem_busy)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: outstanding reads as (due cycle, owner) records.
    typedef struct { int due; bit is_d; } ret_t;
    ret_t pend[$];
    int   cyc    = 0;
    int   starve = 0;
    bit   hold_rdata = 1'b0;

    logic        e_ig, e_dg, e_rd, e_wr, e_iv, e_dv;
    logic [15:0] e_addr, e_wd, e_ird, e_drd;
    logic        s_ig, s_dg, s_rd, s_wr, s_iv, s_dv, s_any;
    logic [15:0] s_addr, s_wd, s_ird, s_drd;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%04h want=%04h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        bit ie, de, ifirst;
        ie     = rst && i_req && !mem_stall && !mem_busy[i_addr[2:1]];
        de     = rst && d_req && !mem_stall && !mem_busy[d_addr[2:1]];
        ifirst = FAIR && (starve >= STARVE);
        e_ig = 1'b0; e_dg = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = 16'h0; e_wd = 16'h0;
        if (de && !(ie && ifirst)) begin
            e_dg = 1'b1;
            e_addr = d_addr;
            if (d_wr) begin e_wr = 1'b1; e_wd = d_wdata; end
            else e_rd = 1'b1;
        end else if (ie) begin
            e_ig = 1'b1; e_rd = 1'b1; e_addr = i_addr;
        end
        e_iv = 1'b0; e_dv = 1'b0; e_ird = 16'h0; e_drd = 16'h0;
        if (rst) begin
            foreach (pend[k]) begin
                if (pend[k].due == cyc) begin
                    if (pend[k].is_d) begin e_dv = 1'b1; e_drd = mem_rdata; end
                    else begin e_iv = 1'b1; e_ird = mem_rdata; end
                end
            end
        end
    endtask

    task automatic model_commit();
        if (!rst) begin
            pend.delete();
            starve = 0;
        end else begin
            while (pend.size() > 0 && pend[0].due <= cyc) pend.delete(0);
            if (e_ig) pend.push_back('{cyc + LAT, 1'b0});
            if (e_dg && e_rd) pend.push_back('{cyc + LAT, 1'b1});
            if (e_ig || !i_req) starve = 0;
            else if (e_dg && starve < STARVE) starve++;
        end
        cyc++;
    endtask

    // Called just after a posedge with inputs already set for this cycle.
    task automatic tick();
        if (!hold_rdata) mem_rdata = 16'($urandom);
        @(negedge clk);
        model_eval();
        s_ig = i_gnt; s_dg = d_gnt; s_rd = mem_rd; s_wr = mem_wr;
        s_iv = i_valid; s_dv = d_valid; s_addr = mem_addr; s_wd = mem_wdata;
        s_ird = i_rdata; s_drd = d_rdata;
        s_any = |{i_gnt, d_gnt, mem_rd, mem_wr, i_valid, d_valid,
                  mem_addr, mem_wdata, i_rdata, d_rdata};
        chk1 ("i_gnt",     i_gnt,     e_ig);
        chk1 ("d_gnt",     d_gnt,     e_dg);
        chk1 ("mem_rd",    mem_rd,    e_rd);
        chk1 ("mem_wr",    mem_wr,    e_wr);
        chk16("mem_addr",  mem_addr,  e_addr);
        chk16("mem_wdata", mem_wdata, e_wd);
        chk1 ("i_valid",   i_valid,   e_iv);
        chk16("i_rdata",   i_rdata,   e_ird);
        chk1 ("d_valid",   d_valid,   e_dv);
        chk16("d_rdata",   d_rdata,   e_drd);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0; mem_stall = 1'b0; mem_busy = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    typedef struct {
        logic rst, ir; logic [15:0] ia;
        logic dr, dw;  logic [15:0] da, dwd;
        logic st;      logic [3:0] busy;
        logic eig, edg, erd, ewr; logic [15:0] eaddr, ewd;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ndg;
        clear_inputs();
        rst = 1'b0;
        mem_rdata = 16'h0;
        @(posedge clk); #1;

        // Reset held three cycles, then one I read with fixed return data.
        hold_rdata = 1'b1;
        mem_rdata = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("rst_outputs_zero", s_any, 1'b0);
        end
        rst = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        chk1 ("first_rd_gnt",  s_ig,   1'b1);
        chk1 ("first_rd_cmd",  s_rd,   1'b1);
        chk16("first_rd_addr", s_addr, 16'h0010);
        i_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk1("first_rd_valid", s_iv, k == LAT);
            if (k == LAT) chk16("first_rd_data", s_ird, 16'hBEEF);
        end
        hold_rdata = 1'b0;

        // Single-cycle grant vectors.
        tbl[0]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0102, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000};
        tbl[4]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h1234};
        tbl[7]  = '{1'b1, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 1'b0, 16'h0009, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0000};
        tbl[10] = '{1'b1, 1'b1, 16'h0030, 1'b1, 1'b1, 16'h0040, 16'hA5A5, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'hA5A5};
        tbl[11] = '{1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        foreach (tbl[v]) begin
            rst = tbl[v].rst; i_req = tbl[v].ir; i_addr = tbl[v].ia;
            d_req = tbl[v].dr; d_wr = tbl[v].dw; d_addr = tbl[v].da; d_wdata = tbl[v].dwd;
            mem_stall = tbl[v].st; mem_busy = tbl[v].busy;
            tick();
            chk1 ("tbl_i_gnt",     s_ig,   tbl[v].eig);
            chk1 ("tbl_d_gnt",     s_dg,   tbl[v].edg);
            chk1 ("tbl_mem_rd",    s_rd,   tbl[v].erd);
            chk1 ("tbl_mem_wr",    s_wr,   tbl[v].ewr);
            chk16("tbl_mem_addr",  s_addr, tbl[v].eaddr);
            chk16("tbl_mem_wdata", s_wd,   tbl[v].ewd);
        end
        rst = 1'b1;
        clear_inputs();
        idle(LAT + 1);

        // Simultaneous reads: D first, I next, returns in order without crossover.
        i_req = 1'b1; i_addr = 16'h0000; d_req = 1'b1; d_addr = 16'h0002;
        tick();
        chk1("simul_d_first", s_dg, 1'b1);
        chk1("simul_i_wait",  s_ig, 1'b0);
        d_req = 1'b0;
        tick();
        chk1("simul_i_next", s_ig, 1'b1);
        i_req = 1'b0;
        for (int k = 2; k <= LAT + 1; k++) begin
            tick();
            chk1("simul_d_valid", s_dv, k == LAT);
            chk1("simul_i_valid", s_iv, k == LAT + 1);
        end
        clear_inputs();
        idle(LAT + 1);

        // Busy bank on D does not block I.
        mem_busy = 4'b0010; d_req = 1'b1; d_addr = 16'h0002; i_req = 1'b1; i_addr = 16'h0004;
        tick();
        chk1("bypass_i_gnt", s_ig, 1'b1);
        chk1("bypass_d_blk", s_dg, 1'b0);
        i_req = 1'b0;
        tick();
        chk1("bypass_d_still_blk", s_dg, 1'b0);
        mem_busy = 4'b0000;
        tick();
        chk1("bypass_d_gnt", s_dg, 1'b1);
        clear_inputs();
        idle(LAT + 1);

        // Write: command only, no return.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
        tick();
        chk1 ("wr_gnt",   s_dg, 1'b1);
        chk1 ("wr_cmd",   s_wr, 1'b1);
        chk1 ("wr_no_rd", s_rd, 1'b0);
        chk16("wr_data",  s_wd, 16'h1234);
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("wr_no_valid", s_dv, 1'b0);
        end

        // Stall blocks grants but not the in-flight return.
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        chk1("stall_pre_gnt", s_ig, 1'b1);
        mem_stall = 1'b1; i_addr = 16'h0014; d_req = 1'b1; d_addr = 16'h0016;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk1("stall_no_gnt", s_ig | s_dg, 1'b0);
            chk1("stall_ret",    s_iv, k == LAT);
        end
        mem_stall = 1'b0;
        tick();
        chk1("stall_d_after", s_dg, 1'b1);
        d_req = 1'b0;
        tick();
        chk1("stall_i_after", s_ig, 1'b1);
        i_req = 1'b0;
        // Reset right after a read grant discards it.
        d_req = 1'b1; d_addr = 16'h0006;
        tick();
        chk1("midrst_gnt", s_dg, 1'b1);
        d_req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            chk1("midrst_no_valid", s_iv | s_dv, 1'b0);
        end

        // Starvation: D streams to alternating free banks while I waits.
        rst = 1'b0; tick(); rst = 1'b1;
        ndg = 0;
        i_req = 1'b1; i_addr = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            d_req = 1'b1; d_wr = 1'b0;
            d_addr = (ndg % 2 == 1) ? 16'h0004 : 16'h0002;
            tick();
            chk1("fair_i_gnt", s_ig, FAIR && (k == 4));
            chk1("fair_d_gnt", s_dg, !(FAIR && (k == 4)));
            if (e_dg) ndg++;
            if (e_ig) i_req = 1'b0;
        end
        d_req = 1'b0;
        if (i_req) begin
            tick();
            chk1("fair_i_drain", s_ig, 1'b1);
        end
        clear_inputs();
        idle(LAT + 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if (!i_req && $urandom_range(2) != 0) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            if (!d_req && $urandom_range(2) != 0) begin
                d_req = 1'b1; d_wr = 1'($urandom_range(1));
                d_addr = 16'($urandom);
                d_wdata = d_wr ? 16'($urandom) : 16'h0;
            end
            mem_stall = ($urandom_range(5) == 0);
            mem_busy  = 4'($urandom) & 4'($urandom);
            rst       = ($urandom_range(40) != 0);
            tick();
            if (e_ig) i_req = 1'b0;
            if (e_dg) d_req = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
